// File: rtl/nmcu_pkg.sv
// -----------------------------------------------------------------------------
// nmcu_pkg
// Shared memory-port types for the NMCU.
//   mem_req_t  (98 bits): valid, write_en, len (burst beats, 0 means 1),
//                         addr (24-bit word address), wdata (64-bit)
//   mem_resp_t (66 bits): valid, err, rdata (64-bit)
// -----------------------------------------------------------------------------
package nmcu_pkg;

    typedef struct packed {
        logic        valid;
        logic        write_en;
        logic [7:0]  len;
        logic [23:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [63:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/nmcu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// nmcu_mem_arbiter_if
// Bundles the requester-side and memory-side signals of nmcu_mem_arbiter.
//   req_i           per-requester request (NUM_REQ x mem_req_t)
//   req_ready_o     per-requester accept strobe
//   mem_req_o       granted request towards memory
//   mem_req_ready_i memory accepts mem_req_o
//   mem_resp_i      in-order read response from memory
//   resp_o          per-requester routed response
//   busy_o / err_o  status
// Modports: master = the arbiter itself, slave = requesters + memory model.
// -----------------------------------------------------------------------------
interface nmcu_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    import nmcu_pkg::*;

    mem_req_t  [NUM_REQ-1:0] req_i;
    logic      [NUM_REQ-1:0] req_ready_o;
    mem_req_t                mem_req_o;
    logic                    mem_req_ready_i;
    mem_resp_t               mem_resp_i;
    mem_resp_t [NUM_REQ-1:0] resp_o;
    logic                    busy_o;
    logic                    err_o;

    modport master (
        input  req_i,
        input  mem_req_ready_i,
        input  mem_resp_i,
        output req_ready_o,
        output mem_req_o,
        output resp_o,
        output busy_o,
        output err_o
    );

    modport slave (
        output req_i,
        output mem_req_ready_i,
        output mem_resp_i,
        input  req_ready_o,
        input  mem_req_o,
        input  resp_o,
        input  busy_o,
        input  err_o
    );

endinterface

// File: rtl/nmcu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// nmcu_mem_arbiter
// Shares one main-memory port between NUM_REQ requesters. Round-robin grant
// with burst locking (a requester keeps the port for `len` accepted beats),
// an ID FIFO of outstanding reads, and zero-latency routing of in-order read
// responses back to the issuing requester. No latency on the request path.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  nmcu_mem_arbiter_if.master (requests, memory port, responses, status)
// -----------------------------------------------------------------------------
module nmcu_mem_arbiter
    import nmcu_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                rst,
    nmcu_mem_arbiter_if.master  bus
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] FIFO_FULL = MAX_OUTSTANDING[PTR_W:0];

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Control state
    logic [0:0]      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_lock_id;
    logic [7:0]      r_beat_cnt;
    logic            r_err;

    // Outstanding-read ID FIFO
    logic [ID_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [ID_W-1:0] w_grant;
    logic            w_gnt_found;
    int unsigned     w_idx;
    mem_req_t        w_gnt_req;
    logic [7:0]      w_eff_len;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_unexp_resp;
    logic            w_mem_valid;
    logic            w_fire;
    mem_req_t        w_mem_req;
    logic [NUM_REQ-1:0] w_req_ready;
    mem_resp_t [NUM_REQ-1:0] w_resp;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Grant selection: forced to the lock owner while a burst is in flight,
    // otherwise the first valid requester searching from r_rr_ptr.
    always_comb begin
        w_grant     = r_rr_ptr;
        w_gnt_found = 1'b0;
        w_idx       = 0;
        if (r_state == ST_LOCKED) begin
            w_grant     = r_lock_id;
            w_gnt_found = bus.req_i[r_lock_id].valid;
        end else begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                if (!w_gnt_found && bus.req_i[ID_W'(w_idx)].valid) begin
                    w_gnt_found = 1'b1;
                    w_grant     = ID_W'(w_idx);
                end
            end
        end
    end

    assign w_gnt_req    = bus.req_i[w_grant];
    assign w_eff_len    = (w_gnt_req.len == 8'd0) ? 8'd1 : w_gnt_req.len;
    assign w_fifo_full  = (r_count == FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);

    // Outputs are forced to zero while reset is held, regardless of inputs.
    assign w_pop        = !rst && bus.mem_resp_i.valid && !w_fifo_empty;
    assign w_unexp_resp = !rst && bus.mem_resp_i.valid && w_fifo_empty;

    // A read may not push into a full FIFO unless a response frees a slot
    // in the same cycle; writes are never held back.
    assign w_mem_valid = !rst && w_gnt_found &&
                         !(!w_gnt_req.write_en && w_fifo_full && !w_pop);
    assign w_fire      = w_mem_valid && bus.mem_req_ready_i;
    assign w_push      = w_fire && !w_gnt_req.write_en;

    always_comb begin
        w_mem_req = '0;
        if (!rst) begin
            w_mem_req       = w_gnt_req;
            w_mem_req.valid = w_mem_valid;
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_fire) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_resp = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_pop && (r_fifo[r_rd_ptr] == ID_W'(i))) begin
                w_resp[i] = bus.mem_resp_i;
            end
        end
    end

    assign bus.mem_req_o   = w_mem_req;
    assign bus.req_ready_o = w_req_ready;
    assign bus.resp_o      = w_resp;
    assign bus.busy_o      = !rst && ((r_state == ST_LOCKED) || !w_fifo_empty);
    assign bus.err_o       = r_err;

    // Arbitration FSM and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_id  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_fire) begin
                if (r_state == ST_IDLE) begin
                    if (w_eff_len > 8'd1) begin
                        r_state    <= ST_LOCKED;
                        r_lock_id  <= w_grant;
                        r_beat_cnt <= w_eff_len - 8'd1;
                    end else begin
                        r_rr_ptr <= next_id(w_grant);
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt - 8'd1;
                    if (r_beat_cnt == 8'd1) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= next_id(r_lock_id);
                    end
                end
            end
            if (w_unexp_resp) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID FIFO; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_grant;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nmcu_mem_arbiter
// Directed bench for nmcu_mem_arbiter (NUM_REQ=3, MAX_OUTSTANDING=8).
// Inputs are driven 2 time units after the rising edge, outputs sampled 1 unit
// later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_nmcu_mem_arbiter;
    import nmcu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    nmcu_mem_arbiter_if #(.NUM_REQ(3)) bus ();

    nmcu_mem_arbiter #(
        .NUM_REQ         (3),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic we, input logic [7:0] len,
                           input logic [23:0] addr);
        mem_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.write_en = we;
        r.len      = len;
        r.addr     = addr;
        r.wdata    = 64'h00A5_00A5_00A5_00A5;
        bus.req_i[i] = r;
    endtask

    task automatic clr_req(input logic [1:0] i);
        bus.req_i[i] = '0;
    endtask

    task automatic send_resp(input logic [63:0] data);
        mem_resp_t r;
        r       = '0;
        r.valid = 1'b1;
        r.rdata = data;
        bus.mem_resp_i = r;
    endtask

    function automatic logic [2:0] resp_v();
        logic [2:0] v;
        v[0] = bus.resp_o[0].valid;
        v[1] = bus.resp_o[1].valid;
        v[2] = bus.resp_o[2].valid;
        return v;
    endfunction

    task automatic do_reset();
        rst                 = 1'b1;
        bus.req_i           = '0;
        bus.mem_resp_i      = '0;
        bus.mem_req_ready_i = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_id;

        // ---------------- reset state ----------------
        bus.req_i           = '0;
        bus.mem_resp_i      = '0;
        bus.mem_req_ready_i = 1'b1;
        rst                 = 1'b1;
        cyc();
        settle();
        check("rst_mem_valid", 128'(bus.mem_req_o.valid), 128'd0);
        check("rst_req_ready", 128'(bus.req_ready_o), 128'd0);
        check("rst_resp_valid", 128'(resp_v()), 128'd0);
        check("rst_busy", 128'(bus.busy_o), 128'd0);
        check("rst_err", 128'(bus.err_o), 128'd0);
        set_req(2'd0, 1'b0, 8'd1, 24'h5);
        settle();
        check("rst_gates_request", 128'(bus.mem_req_o.valid), 128'd0);
        clr_req(2'd0);
        rst = 1'b0;
        cyc();

        // ---------------- single read ----------------
        set_req(2'd1, 1'b0, 8'd1, 24'h10);
        settle();
        check("single_mem_valid", 128'(bus.mem_req_o.valid), 128'd1);
        check("single_mem_addr", 128'(bus.mem_req_o.addr), 128'h10);
        check("single_req_ready", 128'(bus.req_ready_o), 128'b010);
        cyc();
        clr_req(2'd1);
        settle();
        check("single_busy_outstanding", 128'(bus.busy_o), 128'd1);
        check("single_idle_ready", 128'(bus.req_ready_o), 128'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        send_resp(64'hDEAD_BEEF);
        settle();
        check("single_resp_route", 128'(resp_v()), 128'b010);
        check("single_resp_data", 128'(bus.resp_o[1].rdata), 128'hDEAD_BEEF);
        cyc();
        bus.mem_resp_i = '0;
        settle();
        check("single_busy_drained", 128'(bus.busy_o), 128'd0);
        check("single_resp_cleared", 128'(resp_v()), 128'd0);

        // ---------------- round robin ----------------
        do_reset();
        set_req(2'd0, 1'b0, 8'd1, 24'h100);
        set_req(2'd1, 1'b0, 8'd1, 24'h101);
        set_req(2'd2, 1'b0, 8'd1, 24'h102);
        for (int k = 0; k < 6; k++) begin
            exp_id = 2'(k % 3);
            settle();
            check($sformatf("rr_grant_%0d", k), 128'(bus.req_ready_o), 128'(3'b001 << exp_id));
            check($sformatf("rr_addr_%0d", k), 128'(bus.mem_req_o.addr), 128'(24'h100 + exp_id));
            cyc();
        end
        bus.req_i = '0;
        for (int k = 0; k < 6; k++) begin
            exp_id = 2'(k % 3);
            send_resp(64'h1000 + 64'(k));
            settle();
            check($sformatf("rr_resp_route_%0d", k), 128'(resp_v()), 128'(3'b001 << exp_id));
            check($sformatf("rr_resp_data_%0d", k), 128'(bus.resp_o[exp_id].rdata),
                  128'(64'h1000 + 64'(k)));
            cyc();
        end
        bus.mem_resp_i = '0;
        settle();
        check("rr_busy_drained", 128'(bus.busy_o), 128'd0);

        // ---------------- burst lock with stall ----------------
        do_reset();
        set_req(2'd0, 1'b0, 8'd4, 24'h200);
        set_req(2'd2, 1'b0, 8'd1, 24'h300);
        settle();
        check("burst_beat1", 128'(bus.req_ready_o), 128'b001);
        cyc();
        settle();
        check("burst_beat2", 128'(bus.req_ready_o), 128'b001);
        cyc();
        bus.mem_req_ready_i = 1'b0;
        settle();
        check("burst_stall_valid", 128'(bus.mem_req_o.valid), 128'd1);
        check("burst_stall_addr", 128'(bus.mem_req_o.addr), 128'h200);
        check("burst_stall_ready", 128'(bus.req_ready_o), 128'd0);
        cyc();
        settle();
        check("burst_stall2_addr", 128'(bus.mem_req_o.addr), 128'h200);
        cyc();
        bus.mem_req_ready_i = 1'b1;
        settle();
        check("burst_beat3", 128'(bus.req_ready_o), 128'b001);
        cyc();
        settle();
        check("burst_beat4", 128'(bus.req_ready_o), 128'b001);
        cyc();
        settle();
        check("burst_then_req2", 128'(bus.req_ready_o), 128'b100);
        check("burst_then_req2_addr", 128'(bus.mem_req_o.addr), 128'h300);
        cyc();
        bus.req_i = '0;
        settle();
        check("burst_busy_outstanding", 128'(bus.busy_o), 128'd1);

        // ---------------- FIFO full ----------------
        do_reset();
        set_req(2'd0, 1'b0, 8'd8, 24'h400);
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("fill_beat_%0d", k), 128'(bus.req_ready_o), 128'b001);
            cyc();
        end
        set_req(2'd0, 1'b0, 8'd1, 24'h500);
        set_req(2'd1, 1'b1, 8'd1, 24'h600);
        settle();
        check("full_write_valid", 128'(bus.mem_req_o.valid), 128'd1);
        check("full_write_ready", 128'(bus.req_ready_o), 128'b010);
        cyc();
        clr_req(2'd1);
        settle();
        check("full_read_blocked", 128'(bus.mem_req_o.valid), 128'd0);
        check("full_read_not_ready", 128'(bus.req_ready_o), 128'd0);
        cyc();
        settle();
        check("full_read_still_blocked", 128'(bus.mem_req_o.valid), 128'd0);
        send_resp(64'h77);
        settle();
        check("full_pop_unblocks", 128'(bus.mem_req_o.valid), 128'd1);
        check("full_pop_ready", 128'(bus.req_ready_o), 128'b001);
        check("full_pop_route", 128'(resp_v()), 128'b001);
        cyc();
        bus.req_i      = '0;
        bus.mem_resp_i = '0;
        settle();
        check("full_busy", 128'(bus.busy_o), 128'd1);

        // ---------------- error on empty FIFO ----------------
        do_reset();
        send_resp(64'hBAD);
        settle();
        check("err_nothing_routed", 128'(resp_v()), 128'd0);
        check("err_not_yet", 128'(bus.err_o), 128'd0);
        cyc();
        bus.mem_resp_i = '0;
        settle();
        check("err_set", 128'(bus.err_o), 128'd1);
        cyc();
        cyc();
        settle();
        check("err_sticky", 128'(bus.err_o), 128'd1);
        check("err_busy", 128'(bus.busy_o), 128'd0);

        // ---------------- reset mid-burst ----------------
        do_reset();
        settle();
        check("err_cleared_by_reset", 128'(bus.err_o), 128'd0);
        set_req(2'd0, 1'b0, 8'd4, 24'h700);
        settle();
        check("mid_beat1", 128'(bus.req_ready_o), 128'b001);
        cyc();
        settle();
        check("mid_beat2", 128'(bus.req_ready_o), 128'b001);
        rst = 1'b1;
        settle();
        check("mid_rst_mem_valid", 128'(bus.mem_req_o.valid), 128'd0);
        check("mid_rst_req_ready", 128'(bus.req_ready_o), 128'd0);
        check("mid_rst_busy", 128'(bus.busy_o), 128'd0);
        cyc();
        clr_req(2'd0);
        rst = 1'b0;
        settle();
        check("post_rst_busy", 128'(bus.busy_o), 128'd0);
        check("post_rst_mem_valid", 128'(bus.mem_req_o.valid), 128'd0);
        send_resp(64'h5A5A);
        settle();
        check("stale_nothing_routed", 128'(resp_v()), 128'd0);
        cyc();
        bus.mem_resp_i = '0;
        settle();
        check("stale_err", 128'(bus.err_o), 128'd1);
        set_req(2'd0, 1'b0, 8'd1, 24'h800);
        set_req(2'd1, 1'b0, 8'd1, 24'h900);
        settle();
        check("post_rst_rr_ptr0", 128'(bus.req_ready_o), 128'b001);
        cyc();
        settle();
        check("post_rst_rr_next", 128'(bus.req_ready_o), 128'b010);
        cyc();
        bus.req_i = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
